// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// | Module      : mem_access_unit_if                                        |
// | Description : Request/response bundle between the pipeline MEM stage    |
// |               and the load/store sequencer.                             |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_unit_if;
  logic        i_req_valid;
  logic        i_req_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [1:0]  o_fault;

  // Pipeline side: issues requests, observes completion
  modport master (
    output i_req_valid, i_req_we, i_funct3, i_addr, i_wdata,
    input  o_busy, o_done, o_rdata, o_fault
  );

  // Sequencer side
  modport slave (
    input  i_req_valid, i_req_we, i_funct3, i_addr, i_wdata,
    output o_busy, o_done, o_rdata, o_fault
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// | Module      : mem_access_unit                                           |
// | Description : RV32 load/store sequencer. Turns byte/half/word requests  |
// |               into aligned word accesses, with read-modify-write for    |
// |               sub-word stores and lane extraction for sub-word loads.   |
// |               Optional macro MEM_ACCESS_PERF_EN adds load/store         |
// |               completion counters.                                      |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int MEM_ADDR_BITS = 20
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  input  wire logic        i_clk_enable,
  mem_access_unit_if.slave req,
  output logic             o_mem_write,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_data,
  input  wire logic [31:0] i_mem_data
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0]      o_cnt_loads,
  output logic [31:0]      o_cnt_stores
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [1:0]  fault_q;

  logic        w_accept;
  logic        w_illegal;
  logic        w_oor;
  logic        w_mis;
  logic [1:0]  w_fault;
  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_load_val;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  assign w_accept = (state_q == S_IDLE) && req.i_req_valid;

  // Classify the incoming request; illegal size beats range beats alignment
  always_comb begin
    w_illegal = req.i_req_we ? (req.i_funct3 > 3'd2)
                             : ((req.i_funct3 == 3'd3) || (req.i_funct3 == 3'd6) ||
                                (req.i_funct3 == 3'd7));
    w_oor     = (req.i_addr >> MEM_ADDR_BITS) != 32'd0;
    w_mis     = ((req.i_funct3[1:0] == 2'b01) && req.i_addr[0]) ||
                ((req.i_funct3[1:0] == 2'b10) && (req.i_addr[1:0] != 2'b00));
    w_fault   = 2'b00;
    if (w_illegal)  w_fault = 2'b10;
    else if (w_oor) w_fault = 2'b11;
    else if (w_mis) w_fault = 2'b01;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    w_shift = {addr_q[1:0], 3'b000};
    w_lane  = i_mem_data >> w_shift;
    case (f3_q)
      3'b000:  w_load_val = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_val = {24'd0, w_lane[7:0]};
      3'b101:  w_load_val = {16'd0, w_lane[15:0]};
      default: w_load_val = i_mem_data;
    endcase
    w_mask   = (f3_q[1:0] == 2'b00) ? (32'h0000_00FF << w_shift)
                                    : (32'h0000_FFFF << w_shift);
    w_merged = (i_mem_data & ~w_mask) | ((wdata_q << w_shift) & w_mask);
  end

  // State register; reset wins over the clock enable
  always_ff @(posedge i_clk) begin
    if (i_rst)             state_q <= S_IDLE;
    else if (i_clk_enable) state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req.i_req_valid) begin
          if (w_fault != 2'b00)           state_d = S_DONE;
          else if (!req.i_req_we)         state_d = S_LOAD;
          else if (req.i_funct3 == 3'd2)  state_d = S_WRITE;
          else                            state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_DONE;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, load result and merge word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 2'b00;
    end else if (i_clk_enable) begin
      if (w_accept) begin
        addr_q  <= req.i_addr;
        wdata_q <= req.i_wdata;
        f3_q    <= req.i_funct3;
        we_q    <= req.i_req_we;
        merge_q <= req.i_wdata;
        rdata_q <= 32'd0;
        fault_q <= w_fault;
      end else if (state_q == S_LOAD) begin
        rdata_q <= w_load_val;
      end else if (state_q == S_RMW_RD) begin
        merge_q <= w_merged;
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    req.o_busy  = (state_q != S_IDLE);
    req.o_done  = (state_q == S_DONE);
    o_mem_write = (state_q == S_WRITE) && i_clk_enable && !i_rst;
    o_mem_addr  = (state_q == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    o_mem_data  = (state_q == S_WRITE) ? merge_q : 32'd0;
  end

  assign req.o_rdata = rdata_q;
  assign req.o_fault = fault_q;

`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] cnt_loads_q;
  logic [31:0] cnt_stores_q;

  // Count successful completions, once per enabled DONE cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_loads_q  <= 32'd0;
      cnt_stores_q <= 32'd0;
    end else if (i_clk_enable && (state_q == S_DONE) && (fault_q == 2'b00)) begin
      if (we_q) cnt_stores_q <= cnt_stores_q + 32'd1;
      else      cnt_loads_q  <= cnt_loads_q + 32'd1;
    end
  end

  assign o_cnt_loads  = cnt_loads_q;
  assign o_cnt_stores = cnt_stores_q;
`endif

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the pipeline MEM stage and the byte-addressed 32-bit data memory (little-endian; combinational read, synchronous 4-byte write).
- Converts RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word accesses.
  - Performs read-modify-write for sub-word stores.
  - Extracts and extends sub-word loads.
- Stalls the pipeline via o_busy until done.

Parameters:
- MEM_ADDR_BITS, 20, number of valid byte-address bits; addresses with any bit set at or above this position are out of range.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_clk_enable  in  1  global clock enable; when low, all state and counters hold
- i_req_valid  in  1  request present from MEM stage
- i_req_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32 size/sign field
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-justified
- o_busy  out  1  high whenever state is not IDLE; the pipeline stalls on it
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  load result, valid while o_done is high
- o_fault  out  2  fault code, valid while o_done is high: 00 ok, 01 misaligned, 10 illegal funct3, 11 out of range
- o_mem_write  out  1  memory write strobe
- o_mem_addr  out  32  word-aligned memory address
- o_mem_data  out  32  memory write data
- i_mem_data  in  32  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset: state IDLE; o_busy, o_done, o_mem_write = 0; o_rdata, o_fault, o_mem_addr, o_mem_data = 0. Reset overrides i_clk_enable.
- Clock enable: when i_clk_enable is low, the FSM holds and o_mem_write is forced to 0.
- Acceptance: a request is accepted only in IDLE with i_req_valid=1. It latches addr, wdata, funct3, we. Requests arriving while busy are ignored; the pipeline holds them via o_busy.
- Fault checks at accept, first match wins:
  - illegal funct3 (load: 3, 6, 7; store: 3 to 7) → 10
  - out of range (addr >> MEM_ADDR_BITS != 0) → 11
  - misaligned (half with addr[0]=1; word with addr[1:0]!=0) → 01
  - A faulting request goes directly to DONE with o_rdata=0 and performs no memory write.
- Memory address: o_mem_addr = {latched addr[31:2], 2'b00} in all non-IDLE states; 0 in IDLE.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
  - IDLE → LOAD for a load.
  - IDLE → WRITE for SW.
  - IDLE → RMW_RD for SB/SH.
  - IDLE → DONE on any fault.
  - LOAD: capture i_mem_data, extract the lane → DONE.
  - RMW_RD: capture i_mem_data into the merge register → WRITE.
  - WRITE: o_mem_write=1, o_mem_data = merged word (SW: wdata) → DONE.
  - DONE: o_done=1 for one cycle, o_busy=1 → IDLE. A new request may be accepted in the following IDLE cycle.
- Latency from accept to o_done:
  - loads and SW: 2 cycles
  - SB/SH: 3 cycles
  - faults: 1 cycle
- Lane rules: byte lane k = bits[8k+7:8k], with k = addr[1:0].
  - LB/LBU: sign-extend / zero-extend the byte at lane k.
  - LH/LHU: sign-extend / zero-extend the halfword at lanes k, k+1 (k is 0 or 2).
  - SB: replace lane k with wdata[7:0].
  - SH: replace lanes k, k+1 with wdata[15:0].
  - All other lanes keep their read values.
- Reset mid-operation: returns to IDLE with no write issued. A reset asserted in WRITE suppresses o_mem_write that cycle.
- Memory write timing: o_mem_write asserts only in the WRITE state, for exactly one enabled cycle.

Optional Feature:
- Macro: MEM_ACCESS_PERF_EN.
- Defined:
  - Adds ports o_cnt_loads (out, 32) and o_cnt_stores (out, 32), both reset to 0.
  - Each increments by 1 on o_done for a non-faulting load / store respectively, and wraps at 0xFFFFFFFF→0.
  - Both hold when i_clk_enable is low.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Preload the word at 0x100 = 0x8899AABB:
  - LB 0x101 → o_rdata 0xFFFFFFAA, o_fault 00, o_done 2 cycles after accept.
  - LBU 0x103 → o_rdata 0x00000088.
  - LH 0x102 → o_rdata 0xFFFF8899.
- SB 0x101 with wdata 0x12345655 → exactly one o_mem_write at addr 0x100 with data 0x889955BB, o_done 3 cycles after accept; a subsequent LW 0x100 returns 0x889955BB.
- SH 0x103 → o_fault 01, o_done 1 cycle after accept, no o_mem_write. LW 0x200000 with MEM_ADDR_BITS=20 → o_fault 11. Load with funct3=3 → o_fault 10, o_rdata 0.
- SW 0x104 = 0xDEADBEEF with i_clk_enable held low for 3 cycles in WRITE → state holds, write occurs only on the first enabled cycle, o_done follows.
- Assert i_rst during RMW_RD of an SB → no write, o_busy 0 the next cycle, memory unchanged.
- With MEM_ACCESS_PERF_EN: 3 loads + 2 stores + 1 faulting store → o_cnt_loads 3, o_cnt_stores 2.
